// File: rtl/armaria_pkg.sv
// Shared encodings and constants for the armaria core: stack operations,
// privilege modes, the empty-stack sentinel and the exception vector.
package armaria_pkg;

  typedef enum logic [1:0] {
    STACK_NONE = 2'd0,
    STACK_PUSH = 2'd1,
    STACK_POP  = 2'd2,
    STACK_RSVD = 2'd3
  } stack_op_e;

  typedef enum logic {
    MODE_USER = 1'b0,
    MODE_PRIV = 1'b1
  } mode_e;

  localparam logic [31:0] SP_EMPTY         = 32'hFFFF_FFFF;
  localparam int          EXCEPTION_VECTOR = 1;

endpackage

// File: rtl/privilege_mode_fsm.sv
// Two-state privilege FSM. Decides whether this cycle takes an exception or
// a return, and holds the mode seen by the SP bank select.
module privilege_mode_fsm
  import armaria_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic exception_request,
  input  logic exception_return,
  output logic mode_flag,
  output logic take_exception,
  output logic take_return
);

  mode_e state_reg;
  mode_e state_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= MODE_PRIV;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    take_exception = 1'b0;
    take_return    = 1'b0;
    if (enable) begin
      // A request beats a simultaneous return; a return in user mode is dropped.
      if (exception_request) begin
        take_exception = 1'b1;
        state_next     = MODE_PRIV;
      end else if (exception_return && (state_reg == MODE_PRIV)) begin
        take_return = 1'b1;
        state_next  = MODE_USER;
      end
    end
  end

  assign mode_flag = (state_reg == MODE_PRIV);

endmodule

// File: rtl/pc_sp_register_bank.sv
// Architectural PC / banked SP / privilege state feeding the memory address
// handler; commits the handler's next values on each enabled cycle.
module pc_sp_register_bank #(
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    ADDR_WIDTH       = 14,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET         = '0,
  parameter logic [ADDR_WIDTH-1:0] EXCEPTION_VECTOR = ADDR_WIDTH'(armaria_pkg::EXCEPTION_VECTOR),
  parameter logic [DATA_WIDTH-1:0] SP_EMPTY         = '1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] next_PC,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic [1:0]            stack_op,
  input  logic [DATA_WIDTH-1:0] next_SP,
  input  logic                  exception_request,
  input  logic                  exception_return,
  output logic [DATA_WIDTH-1:0] current_PC,
  output logic [DATA_WIDTH-1:0] current_SP,
  output logic                  privilege_mode_flag,
  output logic [ADDR_WIDTH-1:0] saved_PC,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);

  import armaria_pkg::*;

  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] saved_pc_reg;
  logic [DATA_WIDTH-1:0] sp_priv_reg;
  logic [DATA_WIDTH-1:0] sp_user_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  mode_flag;
  logic                  take_exception;
  logic                  take_return;
  logic                  push;
  logic                  pop;
  logic                  overflow_hit;
  logic                  underflow_hit;

  privilege_mode_fsm u_mode_fsm (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .exception_request (exception_request),
    .exception_return  (exception_return),
    .mode_flag         (mode_flag),
    .take_exception    (take_exception),
    .take_return       (take_return)
  );

  assign push = (stack_op == STACK_PUSH);
  assign pop  = (stack_op == STACK_POP);

  assign current_SP = mode_flag ? sp_priv_reg : sp_user_reg;

  assign overflow_hit  = push && (current_SP != SP_EMPTY) && (next_SP == SP_EMPTY);
  assign underflow_hit = pop && (current_SP == SP_EMPTY);

  always_comb begin
    pc_next = next_PC;
    if (take_exception) begin
      pc_next = EXCEPTION_VECTOR;
    end else if (take_return) begin
      pc_next = saved_pc_reg;
    end else if (branch_taken) begin
      pc_next = branch_target;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg        <= PC_RESET;
      saved_pc_reg  <= '0;
      sp_priv_reg   <= SP_EMPTY;
      sp_user_reg   <= SP_EMPTY;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (enable) begin
      pc_reg <= pc_next;
      if (take_exception) begin
        saved_pc_reg <= next_PC;
      end
      // Bank choice uses the registered mode, so a same-cycle mode change
      // still commits to the bank that was active when the op was issued.
      if (push || pop) begin
        if (mode_flag) begin
          sp_priv_reg <= next_SP;
        end else begin
          sp_user_reg <= next_SP;
        end
      end
      if (overflow_hit) begin
        overflow_reg <= 1'b1;
      end
      if (underflow_hit) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign current_PC          = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, pc_reg};
  assign privilege_mode_flag = mode_flag;
  assign saved_PC            = saved_pc_reg;
  assign stack_overflow      = overflow_reg;
  assign stack_underflow     = underflow_reg;

endmodule

// File: tb/tb_pc_sp_register_bank.sv
// Directed bench for pc_sp_register_bank: reset, PC select priority,
// exception entry/return, SP banking and sticky stack faults.
module tb_pc_sp_register_bank;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [13:0] next_PC;
  logic        branch_taken;
  logic [13:0] branch_target;
  logic [1:0]  stack_op;
  logic [31:0] next_SP;
  logic        exception_request;
  logic        exception_return;
  logic [31:0] current_PC;
  logic [31:0] current_SP;
  logic        privilege_mode_flag;
  logic [13:0] saved_PC;
  logic        stack_overflow;
  logic        stack_underflow;

  int checks = 0;
  int errors = 0;

  pc_sp_register_bank dut (
    .clock               (clock),
    .reset               (reset),
    .enable              (enable),
    .next_PC             (next_PC),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .stack_op            (stack_op),
    .next_SP             (next_SP),
    .exception_request   (exception_request),
    .exception_return    (exception_return),
    .current_PC          (current_PC),
    .current_SP          (current_SP),
    .privilege_mode_flag (privilege_mode_flag),
    .saved_PC            (saved_PC),
    .stack_overflow      (stack_overflow),
    .stack_underflow     (stack_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Check the whole visible state in one go.
  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] sp,
                             input logic flag, input logic [13:0] spc,
                             input logic ovf, input logic unf);
    check({tag, ".pc"}, current_PC, pc);
    check({tag, ".sp"}, current_SP, sp);
    check({tag, ".mode"}, {31'd0, privilege_mode_flag}, {31'd0, flag});
    check({tag, ".saved_pc"}, {18'd0, saved_PC}, {18'd0, spc});
    check({tag, ".ovf"}, {31'd0, stack_overflow}, {31'd0, ovf});
    check({tag, ".unf"}, {31'd0, stack_underflow}, {31'd0, unf});
    $display("step %s: pc=0x%0h sp=0x%0h mode=%0b saved=0x%0h ovf=%0b unf=%0b",
             tag, current_PC, current_SP, privilege_mode_flag, saved_PC,
             stack_overflow, stack_underflow);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    enable            = 1'b1;
    branch_taken      = 1'b0;
    branch_target     = '0;
    stack_op          = 2'd0;
    next_SP           = '0;
    exception_request = 1'b0;
    exception_return  = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    next_PC = '0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    check_state("reset_init", 32'h0, 32'hFFFF_FFFF, 1'b1, 14'h0, 1'b0, 1'b0);
    reset = 1'b1;

    next_PC = 14'h5;
    tick();
    check_state("seq", 32'h5, 32'hFFFF_FFFF, 1'b1, 14'h0, 1'b0, 1'b0);

    branch_taken = 1'b1; branch_target = 14'h200; next_PC = 14'h6;
    tick();
    check_state("branch", 32'h200, 32'hFFFF_FFFF, 1'b1, 14'h0, 1'b0, 1'b0);

    // Stall ignores every input, exception and push included.
    enable = 1'b0; branch_taken = 1'b0; next_PC = 14'h7;
    exception_request = 1'b1; stack_op = 2'd1; next_SP = 32'h55;
    tick();
    check_state("stall", 32'h200, 32'hFFFF_FFFF, 1'b1, 14'h0, 1'b0, 1'b0);

    idle_inputs();
    next_PC = 14'h201; stack_op = 2'd1; next_SP = 32'h17FF;
    tick();
    check_state("priv_push", 32'h201, 32'h17FF, 1'b1, 14'h0, 1'b0, 1'b0);

    idle_inputs();
    next_PC = 14'h202; exception_return = 1'b1;
    tick();
    check_state("ret_to_user", 32'h0, 32'hFFFF_FFFF, 1'b0, 14'h0, 1'b0, 1'b0);

    idle_inputs();
    next_PC = 14'h3; stack_op = 2'd1; next_SP = 32'h1FFF;
    tick();
    check_state("user_push", 32'h3, 32'h1FFF, 1'b0, 14'h0, 1'b0, 1'b0);

    // Exception with a push in the same cycle: SP lands in the user bank.
    idle_inputs();
    next_PC = 14'h41; exception_request = 1'b1; stack_op = 2'd1; next_SP = 32'h1EEE;
    tick();
    check_state("exc_entry", 32'h1, 32'h17FF, 1'b1, 14'h41, 1'b0, 1'b0);

    idle_inputs();
    next_PC = 14'h99; exception_return = 1'b1;
    tick();
    check_state("exc_return", 32'h41, 32'h1EEE, 1'b0, 14'h41, 1'b0, 1'b0);

    idle_inputs();
    next_PC = 14'h50; exception_request = 1'b1; exception_return = 1'b1;
    tick();
    check_state("req_ret_user", 32'h1, 32'h17FF, 1'b1, 14'h50, 1'b0, 1'b0);

    idle_inputs();
    next_PC = 14'h60; exception_request = 1'b1; exception_return = 1'b1;
    tick();
    check_state("req_ret_priv", 32'h1, 32'h17FF, 1'b1, 14'h60, 1'b0, 1'b0);

    idle_inputs();
    next_PC = 14'h2; stack_op = 2'd1; next_SP = 32'h1000;
    tick();
    check_state("sp_1000", 32'h2, 32'h1000, 1'b1, 14'h60, 1'b0, 1'b0);

    idle_inputs();
    next_PC = 14'h3; stack_op = 2'd1; next_SP = 32'hFFFF_FFFF;
    tick();
    check_state("overflow", 32'h3, 32'hFFFF_FFFF, 1'b1, 14'h60, 1'b1, 1'b0);

    idle_inputs();
    next_PC = 14'h10;
    tick();
    check_state("ovf_sticky", 32'h10, 32'hFFFF_FFFF, 1'b1, 14'h60, 1'b1, 1'b0);

    idle_inputs();
    next_PC = 14'h11; stack_op = 2'd3; next_SP = 32'h1234;
    tick();
    check_state("op_rsvd", 32'h11, 32'hFFFF_FFFF, 1'b1, 14'h60, 1'b1, 1'b0);

    idle_inputs();
    next_PC = 14'h12; stack_op = 2'd2; next_SP = 32'h0;
    tick();
    check_state("underflow", 32'h12, 32'h0, 1'b1, 14'h60, 1'b1, 1'b1);

    idle_inputs();
    next_PC = 14'h13; exception_return = 1'b1;
    tick();
    check_state("unf_sticky", 32'h60, 32'h1EEE, 1'b0, 14'h60, 1'b1, 1'b1);

    // Reset asserted mid-cycle must clear state without waiting for an edge.
    idle_inputs();
    branch_taken = 1'b1; branch_target = 14'h0123;
    tick();
    check("pre_reset.pc", current_PC, 32'h123);
    branch_target = 14'h0456; next_SP = 32'h77; stack_op = 2'd1;
    #2;
    reset = 1'b0;
    #1;
    check_state("reset_async", 32'h0, 32'hFFFF_FFFF, 1'b1, 14'h0, 1'b0, 1'b0);
    tick();
    check_state("reset_held", 32'h0, 32'hFFFF_FFFF, 1'b1, 14'h0, 1'b0, 1'b0);
    reset = 1'b1;
    idle_inputs();
    next_PC = 14'h3FFF;
    tick();
    check_state("post_reset", 32'h3FFF, 32'hFFFF_FFFF, 1'b1, 14'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sp_register_bank.md
# pc_sp_register_bank

Architectural state holder directly upstream of the memory address handler. Registers the program counter, two banked stack pointers (privileged/user) and the privilege mode. Feeds `current_PC`, `current_SP` and `privilege_mode_flag` to the handler, and commits its combinational `next_PC`/`next_SP` results each enabled cycle. Also handles exception entry/return and raises sticky stack fault flags.

## Interface
- `DATA_WIDTH`, 32: register/data width.
- `ADDR_WIDTH`, 14: memory word-address width.
- `PC_RESET`, 0: PC value after reset.
- `EXCEPTION_VECTOR`, 1: PC loaded on exception entry.
- `SP_EMPTY`, (2**DATA_WIDTH)-1: empty-stack sentinel.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `enable` in 1: commit strobe; low = stall, all state holds.
- `next_PC` in ADDR_WIDTH: sequential PC from the handler.
- `branch_taken` in 1: load `branch_target` instead of `next_PC`.
- `branch_target` in ADDR_WIDTH: branch destination.
- `stack_op` in 2: 0 none, 1 push, 2 pop, 3 reserved (treated as none).
- `next_SP` in DATA_WIDTH: SP result from the handler.
- `exception_request` in 1: enter privileged mode at vector.
- `exception_return` in 1: restore saved PC and return to user mode.
- `current_PC` out DATA_WIDTH: zero-extended PC register.
- `current_SP` out DATA_WIDTH: SP of the active bank (combinational mux of registers).
- `privilege_mode_flag` out 1: 1 = privileged.
- `saved_PC` out ADDR_WIDTH: return address latched on exception.
- `stack_overflow`, `stack_underflow` out 1: sticky fault flags.

## Operation
- Mode FSM has two states, PRIV (flag 1) and USER (flag 0).
  - Reset → PRIV.
  - `exception_request` → PRIV from either state.
  - `exception_return` in PRIV → USER.
  - `exception_return` in USER is ignored.
- PC next-value priority on an enabled cycle:
  1. `exception_request` → `EXCEPTION_VECTOR`, and `saved_PC` <= `next_PC`. This always overwrites `saved_PC`; nested exceptions lose the older return address.
  2. `exception_return` (PRIV only) → `saved_PC`.
  3. `branch_taken` → `branch_target`.
  4. Otherwise → `next_PC`.
- SP commit: when `stack_op` is 1 or 2, the bank selected by the mode held at the start of the cycle is loaded with `next_SP`. The other bank never changes.
- An exception or return in the same cycle as a stack op still commits the SP to the old bank.
- Overflow: `stack_op`=1, `current_SP` != `SP_EMPTY` and `next_SP` == `SP_EMPTY` → `stack_overflow` set. This covers a push onto a full stack.
- Underflow: `stack_op`=2 and `current_SP` == `SP_EMPTY` → `stack_underflow` set.
- Flags clear only on reset. A flag being set does not block the SP commit.
- PC arithmetic is ADDR_WIDTH wide; `current_PC` upper bits are always 0.

## Timing
- All registers update on the rising `clock` edge when `enable`=1, one-cycle latency. Outputs reflect the new state in the following cycle.
- `current_SP` switches bank in the cycle after the mode change.
- Reset values, applied asynchronously:
  - PC = `PC_RESET`
  - both SP banks = `SP_EMPTY`
  - mode = PRIV
  - `saved_PC` = 0
  - both flags = 0
- Reset is asserted immediately mid-operation; any pending commit is discarded.
- `enable`=0 ignores every input, including exceptions. The requester holds `exception_request` until a cycle in which `enable`=1.
- Reset release is synchronised by the system; no internal synchroniser.

## Structure
- Shared package `armaria_pkg`:
  - stack_op encodings (`STACK_NONE`/`PUSH`/`POP`)
  - `SP_EMPTY`
  - `EXCEPTION_VECTOR`
  - mode encoding (`MODE_USER`=0, `MODE_PRIV`=1)
- One sub-module, `privilege_mode_fsm`: two-state FSM. Its outputs are the mode flag, `take_exception` and `take_return`, which feed the PC-select and saved_PC logic.
- SP banks, PC, `saved_PC` and fault flags live in the top module.

## Test plan
- **Reset:** assert `reset`=0 mid-run with PC=0x0123. Required immediately: PC=0, `current_SP`=0xFFFFFFFF, flag=1, faults=0.
- **Sequential/branch:** `next_PC`=5, `branch_taken`=0 → `current_PC`=5. Then `branch_taken`=1, `branch_target`=0x200 → 0x200. With `enable`=0 the PC holds at 0x200.
- **Exception entry/return:**
  - In USER, `next_PC`=0x41 with `exception_request` → PC=1, flag=1, `saved_PC`=0x41.
  - Then `exception_return` → PC=0x41, flag=0.
  - Simultaneous request+return → request wins.
- **Banked SP:**
  - In PRIV, push with `next_SP`=0x17FF → privileged SP=0x17FF.
  - Return to USER → `current_SP`=0xFFFFFFFF.
  - Push with `next_SP`=0x1FFF → user SP=0x1FFF; privileged SP still 0x17FF.
- **Overflow:** `current_SP`=0x1000, push with `next_SP`=0xFFFFFFFF → `stack_overflow`=1, SP=0xFFFFFFFF. The flag stays set through later normal ops.
- **Underflow:** `current_SP`=0xFFFFFFFF, `stack_op`=2 → `stack_underflow`=1. `stack_op`=3 → no SP change, no flag.
